// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side handshake and serial line bundle for uart_tx_fifo
interface uart_tx_fifo_if;
  logic [7:0] data;
  logic       send;
  logic       clear;
  logic       ready;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       tx;

  modport master (
    output data, send, clear,
    input  ready, busy, done, overflow, tx
  );

  modport slave (
    input  data, send, clear,
    output ready, busy, done, overflow, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 LSB-first UART transmitter fed by a small byte FIFO
module uart_tx_fifo #(
  parameter int clock_frequency = 12000000,
  parameter int baud_rate       = 9600,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);
  localparam int CPB = clock_frequency / baud_rate;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [15:0]   BAUD_RELOAD = 16'(CPB - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q;
  logic          push, pop, fifo_empty, baud_done;

  assign bus.ready    = (count != FULL_COUNT);
  assign push         = bus.send & bus.ready;
  assign pop          = (state_q == LOAD);
  assign fifo_empty   = (count == '0);
  assign baud_done    = (baud_q == '0);
  assign bus.busy     = (state_q != IDLE) | ~fifo_empty;
  assign bus.done     = (state_q == STOP) & baud_done;
  assign bus.overflow = overflow_q;
  assign bus.tx       = tx_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped push still flags overflow when a pop frees a slot that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow_q <= 1'b0;
    else if (bus.send && !bus.ready) overflow_q <= 1'b1;
    else if (bus.clear)              overflow_q <= 1'b0;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        shift_d = mem[rd_ptr];
        baud_d  = BAUD_RELOAD;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_done) state_d = fifo_empty ? IDLE : LOAD;
        else           baud_d  = baud_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the upcoming state so each bit lines up with its state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a cycle-exact serial monitor
module tb_uart_tx_fifo;
  logic clk;
  logic rst_n;
  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .clock_frequency(8),
    .baud_rate      (1),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   failures    = 0;
  int   done_total  = 0;
  int   exp_frames  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller sits at a negedge; returns one negedge later with send released.
  task automatic push(input logic [7:0] d, input logic exp_ready, input int gap,
                      input logic clr, input logic track);
    bus.data  = d;
    bus.send  = 1'b1;
    bus.clear = clr;
    check("push_ready", 32'(bus.ready), 32'(exp_ready));
    if (exp_ready && track) begin
      sb.push_back(exp_t'{d, gap});
      exp_frames++;
    end
    @(negedge clk);
    bus.send  = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Reference receiver: every frame must be exactly 8 low, 8x8 data, 8 high cycles.
  initial begin
    int         k;
    int         high_run;
    int         frame_gap;
    logic       in_frame;
    logic       shape_err;
    logic [7:0] got;
    exp_t       e;
    k = 0; high_run = 0; frame_gap = 0; in_frame = 1'b0; shape_err = 1'b0; got = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        high_run = 0;
      end else begin
        if (bus.done === 1'b1) done_total++;
        if (!in_frame) begin
          if (bus.tx === 1'b0) begin
            in_frame  = 1'b1;
            k         = 0;
            frame_gap = high_run + 8;
            shape_err = 1'b0;
            got       = '0;
          end else begin
            high_run++;
          end
        end
        if (in_frame) begin
          if (k < 8) begin
            if (bus.tx !== 1'b0) shape_err = 1'b1;
          end else if (k < 72) begin
            if (k % 8 == 0) got[(k - 8) / 8] = bus.tx;
            else if (bus.tx !== got[(k - 8) / 8]) shape_err = 1'b1;
          end else if (bus.tx !== 1'b1) begin
            shape_err = 1'b1;
          end
          if (bus.done !== (k == 79)) shape_err = 1'b1;
          if (k == 79) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_frame actual=%0h required=none", got);
            end else begin
              e = sb.pop_front();
              check("frame_data", 32'(got), 32'(e.data));
              check("frame_shape", 32'(shape_err), 32'd0);
              if (e.gap >= 0) check("frame_gap", 32'(frame_gap), 32'(e.gap));
            end
            in_frame = 1'b0;
            high_run = 0;
          end else begin
            k++;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int d0;
    rst_n     = 1'b0;
    bus.data  = '0;
    bus.send  = 1'b0;
    bus.clear = 1'b0;

    // T1 reset
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // T2 single byte
    push(8'hA5, 1'b1, -1, 1'b0, 1'b1);
    check("t2_busy_rise", 32'(bus.busy), 32'd1);
    check("t2_tx_e1", 32'(bus.tx), 32'd1);
    @(negedge clk);
    check("t2_tx_load", 32'(bus.tx), 32'd1);
    @(negedge clk);
    check("t2_tx_start", 32'(bus.tx), 32'd0);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t2_done_seen", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("t2_busy_fall", 32'(bus.busy), 32'd0);
    check("t2_done_once", 32'(done_total), 32'd1);
    repeat (4) @(negedge clk);

    // T3 burst of four
    d0 = done_total;
    push(8'h00, 1'b1, -1, 1'b0, 1'b1);
    push(8'hFF, 1'b1, 9, 1'b0, 1'b1);
    push(8'h55, 1'b1, 9, 1'b0, 1'b1);
    push(8'h0F, 1'b1, 9, 1'b0, 1'b1);
    wait_idle("t3_drain");
    check("t3_done_count", 32'(done_total - d0), 32'd4);

    // T4 overflow
    d0 = done_total;
    push(8'h11, 1'b1, -1, 1'b0, 1'b1);
    push(8'h22, 1'b1, 9, 1'b0, 1'b1);
    push(8'h33, 1'b1, 9, 1'b0, 1'b1);
    push(8'h44, 1'b1, 9, 1'b0, 1'b1);
    push(8'h55, 1'b1, 9, 1'b0, 1'b1);
    push(8'h66, 1'b0, 9, 1'b0, 1'b1);
    check("t4_overflow_set", 32'(bus.overflow), 32'd1);
    wait_idle("t4_drain");
    check("t4_done_count", 32'(done_total - d0), 32'd5);
    check("t4_overflow_sticky", 32'(bus.overflow), 32'd1);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check("t4_clear", 32'(bus.overflow), 32'd0);
    push(8'h77, 1'b1, -1, 1'b0, 1'b1);
    push(8'h88, 1'b1, 9, 1'b0, 1'b1);
    push(8'h99, 1'b1, 9, 1'b0, 1'b1);
    push(8'hAA, 1'b1, 9, 1'b0, 1'b1);
    push(8'hBB, 1'b1, 9, 1'b0, 1'b1);
    push(8'hCC, 1'b0, 9, 1'b1, 1'b1);
    check("t4_set_beats_clear", 32'(bus.overflow), 32'd1);
    wait_idle("t4_drain2");

    // T5 reset during data bit 3 of 0x3C
    d0 = done_total;
    push(8'h3C, 1'b1, -1, 1'b0, 1'b0);
    repeat (36) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tx_abort", 32'(bus.tx), 32'd1);
    check("t5_busy_abort", 32'(bus.busy), 32'd0);
    check("t5_ready_abort", 32'(bus.ready), 32'd1);
    check("t5_overflow_abort", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_no_done", 32'(done_total - d0), 32'd0);
    push(8'h81, 1'b1, -1, 1'b0, 1'b1);
    wait_idle("t5_drain");

    // T6 random traffic honouring ready
    for (int i = 0; i < 200; i++) begin
      n = 0;
      while (bus.ready !== 1'b1 && n < 500) begin
        @(negedge clk);
        n++;
      end
      push(8'($urandom_range(0, 255)), 1'b1, -1, 1'b0, 1'b1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle("t6_drain");
    check("t6_no_overflow", 32'(bus.overflow), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("done_vs_frames", 32'(done_total), 32'(exp_frames));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
